// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: opcodes, FSM states and helpers shared by the ALU sequencer.
// The ALU_SEQ_ZERO_FLAG_EN build option is handled in alu_sequencer.sv.
package alu_seq_pkg;

    typedef logic [2:0] op_t;

    localparam op_t OP_ADD  = 3'b000;
    localparam op_t OP_ASHL = 3'b001;
    localparam op_t OP_XNOR = 3'b010;
    localparam op_t OP_DIV2 = 3'b011;
    localparam op_t OP_LOAD = 3'b100;
    localparam op_t OP_PASS = 3'b101;
    localparam op_t OP_CMP2 = 3'b110;
    localparam op_t OP_CLR  = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_WB   = 2'd2
    } state_e;

    function automatic logic op_writes_e(input op_t op);
        return (op == OP_ADD) || (op == OP_ASHL) ||
               (op == OP_DIV2) || (op == OP_CLR);
    endfunction

endpackage

// File: rtl/alu_seq_if.sv
// alu_seq_if: instruction handshake plus the operand/result path to the ALU.
// master = decode + ALU side, slave = the sequencer.
interface alu_seq_if #(
    parameter int WIDTH = 8,
    parameter int OP_W  = 3
);
    logic             instr_valid;
    logic             instr_ready;
    logic [OP_W-1:0]  instr_op;
    logic [WIDTH-1:0] instr_operand;
    logic [WIDTH-1:0] alu_ac;
    logic [WIDTH-1:0] alu_dr;
    logic [OP_W-1:0]  alu_sel;
    logic [WIDTH-1:0] alu_result;
    logic             alu_e;

    modport master (
        output instr_valid, instr_op, instr_operand,
        output alu_result, alu_e,
        input  instr_ready, alu_ac, alu_dr, alu_sel
    );

    modport slave (
        input  instr_valid, instr_op, instr_operand,
        input  alu_result, alu_e,
        output instr_ready, alu_ac, alu_dr, alu_sel
    );
endinterface

// File: rtl/alu_sequencer.sv
// alu_sequencer: IDLE->EXEC->WB control around the 8-bit ALU, owns AC and E.
// Define ALU_SEQ_ZERO_FLAG_EN to add the z_out zero flag.
module alu_sequencer
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int OP_W  = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    alu_seq_if.slave         bus,
    output logic [WIDTH-1:0] ac_out,
    output logic             e_out,
    output logic             done
`ifdef ALU_SEQ_ZERO_FLAG_EN
    ,
    output logic             z_out
`endif
);

    state_e           state_q, state_d;
    logic [OP_W-1:0]  op_q, op_d;
    logic [WIDTH-1:0] dr_q, dr_d;
    logic [WIDTH-1:0] ac_q, ac_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             e_q, e_d;
    logic             ecap_q, ecap_d;
    logic             done_q, done_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            dr_q    <= '0;
            ac_q    <= '0;
            res_q   <= '0;
            e_q     <= 1'b0;
            ecap_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            dr_q    <= dr_d;
            ac_q    <= ac_d;
            res_q   <= res_d;
            e_q     <= e_d;
            ecap_q  <= ecap_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        op_d            = op_q;
        dr_d            = dr_q;
        ac_d            = ac_q;
        res_d           = res_q;
        e_d             = e_q;
        ecap_d          = ecap_q;
        done_d          = 1'b0;
        bus.instr_ready = 1'b0;
        bus.alu_sel     = OP_PASS;
        unique case (state_q)
            S_IDLE: begin
                bus.instr_ready = 1'b1;
                if (bus.instr_valid) begin
                    op_d    = bus.instr_op;
                    dr_d    = bus.instr_operand;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                // clear never reaches the ALU; it keeps seeing the benign pass
                if (op_q == OP_CLR) begin
                    res_d  = '0;
                    ecap_d = 1'b0;
                end else begin
                    bus.alu_sel = op_q;
                    res_d       = bus.alu_result;
                    ecap_d      = bus.alu_e;
                end
                state_d = S_WB;
            end
            S_WB: begin
                ac_d = res_q;
                if (op_writes_e(op_q)) begin
                    e_d = ecap_q;
                end
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.alu_ac = ac_q;
    assign bus.alu_dr = dr_q;
    assign ac_out     = ac_q;
    assign e_out      = e_q;
    assign done       = done_q;

`ifdef ALU_SEQ_ZERO_FLAG_EN
    logic z_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            z_q <= 1'b0;
        end else if (state_q == S_WB) begin
            z_q <= (res_q == '0);
        end
    end

    assign z_out = z_q;
`endif

endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: directed vectors, a stub ALU and a per-cycle
// architectural model of AC/E/Z for the ALU sequencer.
module tb_alu_sequencer;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic [7:0] ac_out;
    logic       e_out;
    logic       done;
`ifdef ALU_SEQ_ZERO_FLAG_EN
    logic       z_out;
`endif

    int cnt_checks = 0;
    int cnt_err    = 0;

    alu_seq_if #(.WIDTH(8), .OP_W(3)) bus ();

    alu_sequencer #(.WIDTH(8), .OP_W(3)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus    (bus.slave),
        .ac_out (ac_out),
        .e_out  (e_out),
        .done   (done)
`ifdef ALU_SEQ_ZERO_FLAG_EN
        ,
        .z_out  (z_out)
`endif
    );

    always #5 clk = ~clk;

    // Stub ALU; junk carry on non-carry ops and junk on sel 7 expose misuse
    always_comb begin
        bus.alu_result = bus.alu_ac;
        bus.alu_e      = 1'b0;
        case (bus.alu_sel)
            3'd0: {bus.alu_e, bus.alu_result} = {1'b0, bus.alu_ac} + {1'b0, bus.alu_dr};
            3'd1: {bus.alu_e, bus.alu_result} = {bus.alu_ac, 1'b0};
            3'd2: begin
                bus.alu_result = ~(bus.alu_ac ^ bus.alu_dr);
                bus.alu_e      = bus.alu_result[0];
            end
            3'd3: begin
                bus.alu_result = {bus.alu_ac[7], bus.alu_ac[7:1]};
                bus.alu_e      = bus.alu_ac[0];
            end
            3'd4: begin
                bus.alu_result = bus.alu_dr;
                bus.alu_e      = bus.alu_dr[0];
            end
            3'd6: begin
                bus.alu_result = 8'(0 - bus.alu_dr);
                bus.alu_e      = bus.alu_result[0];
            end
            3'd7: begin
                bus.alu_result = 8'hFF;
                bus.alu_e      = 1'b1;
            end
            default: begin
                bus.alu_result = bus.alu_ac;
                bus.alu_e      = bus.alu_ac[0];
            end
        endcase
    end

    // Architectural meaning of each opcode: {E candidate, new AC}
    function automatic logic [8:0] spec_op(input logic [2:0] op,
                                           input logic [7:0] ac,
                                           input logic [7:0] dr);
        case (op)
            3'd0:    return {1'b0, ac} + {1'b0, dr};
            3'd1:    return {ac[7], ac[6:0], 1'b0};
            3'd2:    return {1'b0, ~(ac ^ dr)};
            3'd3:    return {ac[0], ac[7], ac[7:1]};
            3'd4:    return {1'b0, dr};
            3'd5:    return {1'b0, ac};
            3'd6:    return {1'b0, 8'(0 - dr)};
            default: return 9'h000;
        endcase
    endfunction

    logic [7:0] m_ac, m_dr;
    logic [2:0] m_op;
    logic       m_e, m_z, m_done;
    int         m_age;

    // m_age: cycles since acceptance, 0 when free to accept
    always @(posedge clk or negedge rst_n) begin
        logic [8:0] r;
        if (!rst_n) begin
            m_ac = 8'h00; m_dr = 8'h00; m_op = 3'd0;
            m_e = 1'b0; m_z = 1'b0; m_done = 1'b0; m_age = 0;
        end else begin
            m_done = 1'b0;
            if (m_age == 0) begin
                if (bus.instr_valid) begin
                    m_op  = bus.instr_op;
                    m_dr  = bus.instr_operand;
                    m_age = 1;
                end
            end else if (m_age == 1) begin
                m_age = 2;
            end else begin
                r = spec_op(m_op, m_ac, m_dr);
                if (m_op inside {3'd0, 3'd1, 3'd3, 3'd7}) m_e = r[8];
                m_ac   = r[7:0];
                m_z    = (r[7:0] == 8'h00);
                m_done = 1'b1;
                m_age  = 0;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        cnt_checks++;
        if (act !== exp) begin
            cnt_err++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            chk("cyc_ready", 32'(bus.instr_ready), 32'(m_age == 0));
            chk("cyc_ac", 32'(ac_out), 32'(m_ac));
            chk("cyc_e", 32'(e_out), 32'(m_e));
            chk("cyc_done", 32'(done), 32'(m_done));
            chk("cyc_alu_ac", 32'(bus.alu_ac), 32'(m_ac));
            if (m_age == 1) begin
                chk("cyc_sel", 32'(bus.alu_sel), 32'((m_op == 3'd7) ? 3'd5 : m_op));
                chk("cyc_alu_dr", 32'(bus.alu_dr), 32'(m_dr));
            end else begin
                chk("cyc_sel", 32'(bus.alu_sel), 32'd5);
            end
`ifdef ALU_SEQ_ZERO_FLAG_EN
            chk("cyc_z", 32'(z_out), 32'(m_z));
`endif
        end
    end

    // Offer op (valid stays high); returns #1 after the accepting edge
    task automatic issue(input logic [2:0] op, input logic [7:0] dr,
                         output longint t_acc);
        int n;
        n = 0;
        bus.instr_op      = op;
        bus.instr_operand = dr;
        bus.instr_valid   = 1'b1;
        forever begin
            @(negedge clk);
            if (bus.instr_ready) break;
            n++;
            if (n > 12) begin
                cnt_checks++;
                cnt_err++;
                $display("FAIL accept_timeout op=%0d t=%0t", op, $time);
                break;
            end
        end
        @(posedge clk);
        t_acc = longint'($time);
        #1;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (n < 6) begin
            @(posedge clk);
            #1;
            n++;
            if (done) break;
        end
        chk("done_latency", 32'(n), 32'd2);
    endtask

    task automatic run(input logic [2:0] op, input logic [7:0] dr);
        longint t;
        issue(op, dr, t);
        bus.instr_valid = 1'b0;
        wait_done();
    endtask

    initial begin
        longint t0, t1;
        bus.instr_valid   = 1'b0;
        bus.instr_op      = 3'd0;
        bus.instr_operand = 8'h00;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_ac", 32'(ac_out), 32'h00);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_sel", 32'(bus.alu_sel), 32'd5);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_ready", 32'(bus.instr_ready), 32'd1);

        // reset mid-EXEC
        run(3'd4, 8'h5A);
        run(3'd0, 8'hB0);
        chk("t1_ac_pre", 32'(ac_out), 32'h0A);
        chk("t1_e_pre", 32'(e_out), 32'd1);
        issue(3'd5, 8'h00, t0);
        bus.instr_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("t1_ac", 32'(ac_out), 32'h00);
        chk("t1_e", 32'(e_out), 32'd0);
        chk("t1_done", 32'(done), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("t1_ready", 32'(bus.instr_ready), 32'd1);

        // load then add with carry
        run(3'd4, 8'hC1);
        chk("t2_ac_load", 32'(ac_out), 32'hC1);
        chk("t2_e_load", 32'(e_out), 32'd0);
        chk("t2_model_load", 32'(m_ac), 32'hC1);
        run(3'd0, 8'hA3);
        chk("t2_ac_add", 32'(ac_out), 32'h64);
        chk("t2_e_add", 32'(e_out), 32'd1);
        chk("t2_model_e", 32'(m_e), 32'd1);

        // xnor and comp2 hold E
        run(3'd2, 8'h86);
        chk("t3_ac_xnor", 32'(ac_out), 32'h1D);
        chk("t3_e_xnor", 32'(e_out), 32'd1);
        run(3'd6, 8'h9A);
        chk("t3_ac_cmp2", 32'(ac_out), 32'h66);
        chk("t3_e_cmp2", 32'(e_out), 32'd1);
        chk("t3_model", 32'(m_ac), 32'h66);

        // clear, then load 01 (odd operand must not leak into E)
        run(3'd7, 8'h5F);
        chk("t4_ac_clr", 32'(ac_out), 32'h00);
        chk("t4_e_clr", 32'(e_out), 32'd0);
`ifdef ALU_SEQ_ZERO_FLAG_EN
        chk("t4_z_clr", 32'(z_out), 32'd1);
`endif
        run(3'd4, 8'h01);
        chk("t4_ac_ld", 32'(ac_out), 32'h01);
        chk("t4_e_ld", 32'(e_out), 32'd0);
`ifdef ALU_SEQ_ZERO_FLAG_EN
        chk("t4_z_ld", 32'(z_out), 32'd0);
`endif

        // back-to-back with valid held high
        issue(3'd4, 8'h81, t0);
        issue(3'd1, 8'hEE, t1);
        chk("t5_gap1", 32'((t1 - t0) / 10), 32'd3);
        issue(3'd3, 8'h33, t0);
        chk("t5_gap2", 32'((t0 - t1) / 10), 32'd3);
        issue(3'd0, 8'h7F, t1);
        chk("t5_gap3", 32'((t1 - t0) / 10), 32'd3);
        issue(3'd5, 8'h44, t0);
        chk("t5_gap4", 32'((t0 - t1) / 10), 32'd3);
        bus.instr_valid = 1'b0;
        wait_done();
        chk("t5_ac", 32'(ac_out), 32'h80);
        chk("t5_e", 32'(e_out), 32'd0);
        chk("t5_model", 32'(m_ac), 32'h80);

        // reset between WB edge and end of done
        issue(3'd4, 8'h3C, t0);
        bus.instr_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        chk("t6_done_hi", 32'(done), 32'd1);
        chk("t6_ac_hi", 32'(ac_out), 32'h3C);
        rst_n = 1'b0;
        #1;
        chk("t6_done", 32'(done), 32'd0);
        chk("t6_ac", 32'(ac_out), 32'h00);
        @(negedge clk);
        rst_n = 1'b1;
        run(3'd4, 8'h11);
        chk("t6_recover", 32'(ac_out), 32'h11);

        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", cnt_checks, cnt_err);
        $finish;
    end

endmodule
